// File: rtl/kgp_exec_if.sv
// Operand/result handshake bundle between decode/register-read, the execute stage and writeback.
interface kgp_exec_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             carry;
   logic             zero;
   logic             sign;
   logic             diff_eq;

   modport master (
      output in_valid, op, a, b, out_ready,
      input  in_ready, out_valid, result, carry, zero, sign, diff_eq
   );

   modport slave (
      input  in_valid, op, a, b, out_ready,
      output in_ready, out_valid, result, carry, zero, sign, diff_eq
   );
endinterface

// File: rtl/kgp_exec_unit.sv
// Registered execute stage: single-cycle ALU ops plus DIFF, and an iterative 1-bit/cycle shifter.
// state | meaning
// IDLE  | ready to accept an op
// SHIFT | shifting acc one bit per cycle, cnt bits remaining
// DONE  | result/flags valid, held until out_ready
module kgp_exec_unit #(
   parameter int WIDTH = 32,
   parameter int POS_W = 5
) (
   input  logic       clk,
   input  logic       rst_n,
   kgp_exec_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_COMP = 3'd1;
   localparam logic [2:0] OP_AND  = 3'd2;
   localparam logic [2:0] OP_XOR  = 3'd3;
   localparam logic [2:0] OP_SHLL = 3'd4;
   localparam logic [2:0] OP_SHRL = 3'd5;
   localparam logic [2:0] OP_SHRA = 3'd6;
   localparam logic [2:0] OP_DIFF = 3'd7;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] acc;
   logic [POS_W-1:0] cnt;
   logic [2:0]       shop;
   logic [WIDTH-1:0] result_q;
   logic             carry_q, zero_q, sign_q, diff_eq_q;

   logic [POS_W-1:0] amt;
   logic             is_shift, accept, start_shift;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] x;
   logic [POS_W-1:0] diff_pos;
   logic [WIDTH-1:0] alu_res;
   logic             alu_carry, alu_deq;
   logic [WIDTH-1:0] shifted;
   logic             shift_out;

   assign amt         = bus.b[POS_W-1:0];
   assign is_shift    = (bus.op == OP_SHLL) || (bus.op == OP_SHRL) || (bus.op == OP_SHRA);
   assign accept      = (state == IDLE) && bus.in_valid;
   assign start_shift = is_shift && (amt != '0);

   always_comb begin
      sum       = {1'b0, bus.a} + {1'b0, bus.b};
      x         = bus.a ^ bus.b;
      diff_pos  = '0;
      // Scan from the top so the lowest set bit wins.
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (x[i]) diff_pos = POS_W'(i);
      end
      alu_res   = bus.a;
      alu_carry = 1'b0;
      alu_deq   = 1'b0;
      case (bus.op)
         OP_ADD: begin
            alu_res   = sum[WIDTH-1:0];
            alu_carry = sum[WIDTH];
         end
         OP_COMP: alu_res = ~bus.b + WIDTH'(1);
         OP_AND:  alu_res = bus.a & bus.b;
         OP_XOR:  alu_res = bus.a ^ bus.b;
         OP_DIFF: begin
            alu_res = {{(WIDTH-POS_W){1'b0}}, diff_pos};
            alu_deq = (x == '0);
         end
         default: alu_res = bus.a;
      endcase
   end

   always_comb begin
      shifted   = acc;
      shift_out = 1'b0;
      case (shop)
         OP_SHLL: begin
            shifted   = {acc[WIDTH-2:0], 1'b0};
            shift_out = acc[WIDTH-1];
         end
         OP_SHRL: begin
            shifted   = {1'b0, acc[WIDTH-1:1]};
            shift_out = acc[0];
         end
         OP_SHRA: begin
            shifted   = {acc[WIDTH-1], acc[WIDTH-1:1]};
            shift_out = acc[0];
         end
         default: begin
            shifted   = acc;
            shift_out = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.in_valid) state_nxt = start_shift ? SHIFT : DONE;
         SHIFT:   if (cnt == POS_W'(1)) state_nxt = DONE;
         DONE:    if (bus.out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc       <= '0;
         cnt       <= '0;
         shop      <= '0;
         result_q  <= '0;
         carry_q   <= 1'b0;
         zero_q    <= 1'b0;
         sign_q    <= 1'b0;
         diff_eq_q <= 1'b0;
      end else if (accept) begin
         if (start_shift) begin
            acc       <= bus.a;
            cnt       <= amt;
            shop      <= bus.op;
            diff_eq_q <= 1'b0;
         end else begin
            result_q  <= alu_res;
            carry_q   <= alu_carry;
            zero_q    <= (alu_res == '0);
            sign_q    <= alu_res[WIDTH-1];
            diff_eq_q <= alu_deq;
         end
      end else if (state == SHIFT) begin
         acc     <= shifted;
         cnt     <= cnt - POS_W'(1);
         carry_q <= shift_out;
         if (cnt == POS_W'(1)) begin
            result_q <= shifted;
            zero_q   <= (shifted == '0);
            sign_q   <= shifted[WIDTH-1];
         end
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.result    = result_q;
   assign bus.carry     = carry_q;
   assign bus.zero      = zero_q;
   assign bus.sign      = sign_q;
   assign bus.diff_eq   = diff_eq_q;
endmodule

// File: tb/tb_kgp_exec_unit.sv
// Bench for kgp_exec_unit: directed scenarios plus random ops against an arithmetic reference model.
module tb_kgp_exec_unit;
   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   kgp_exec_if #(.WIDTH(32)) bus ();

   kgp_exec_unit #(.WIDTH(32), .POS_W(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Expected outcome packed as {result, carry, zero, sign, diff_eq}.
   function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [35:0] exp_vec, output int exp_lat);
      logic [31:0] r, x;
      logic [32:0] s;
      logic        c, d;
      int          n;
      n = int'(b[4:0]);
      r = '0; c = 1'b0; d = 1'b0; exp_lat = 1;
      case (op)
         3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32]; end
         3'd1: r = 32'd0 - b;
         3'd2: r = a & b;
         3'd3: r = a ^ b;
         3'd4: begin r = a << n; c = (n > 0) ? a[32-n] : 1'b0; exp_lat = n + 1; end
         3'd5: begin r = a >> n; c = (n > 0) ? a[n-1] : 1'b0; exp_lat = n + 1; end
         3'd6: begin r = $unsigned($signed(a) >>> n); c = (n > 0) ? a[n-1] : 1'b0; exp_lat = n + 1; end
         default: begin
            x = a ^ b;
            d = (x == 0);
            for (int i = 31; i >= 0; i--) if (x[i]) r = i;
         end
      endcase
      exp_vec = {r, c, (r == 0), r[31], d};
   endfunction

   // Issues one op, waits for out_valid (bounded), holds out_ready low for 'hold' cycles while
   // poking in_valid with junk, then completes the handshake.
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int hold, output logic [35:0] got, output int lat);
      logic [35:0] held;
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL in_ready_before_op: got %b want 1", bus.in_ready);
      end
      bus.in_valid = 1'b1; bus.op = op; bus.a = a; bus.b = b;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      lat = 1;
      @(negedge clk);
      while (bus.out_valid !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      got = {bus.result, bus.carry, bus.zero, bus.sign, bus.diff_eq};
      for (int h = 0; h < hold; h++) begin
         bus.in_valid = 1'b1; bus.op = 3'd0; bus.a = $urandom; bus.b = $urandom;
         @(negedge clk);
         held = {bus.result, bus.carry, bus.zero, bus.sign, bus.diff_eq};
         checks++;
         if (held !== got || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL hold_stable: got %h rdy %b vld %b want %h rdy 0 vld 1",
                     held, bus.in_ready, bus.out_valid, got);
         end
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL release: got vld %b rdy %b want vld 0 rdy 1", bus.out_valid, bus.in_ready);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.out_valid, bus.in_ready, bus.result, bus.carry, bus.zero, bus.sign, bus.diff_eq}
          !== {1'b0, 1'b1, 36'h0}) begin
         errors++;
         $display("FAIL reset_state: got vld %b rdy %b res %h c%b z%b s%b d%b want vld 0 rdy 1 all 0",
                  bus.out_valid, bus.in_ready, bus.result, bus.carry, bus.zero, bus.sign, bus.diff_eq);
      end
      rst_n = 1'b1;
   endtask

   // Directed op list: op, a, b, hold
   task automatic test_directed(input string name, input logic [2:0] ops[], input logic [31:0] as[],
                                input logic [31:0] bs[], input int holds[]);
      logic [35:0] got, exp_vec;
      int lat, exp_lat;
      for (int i = 0; i < ops.size(); i++) begin
         model(ops[i], as[i], bs[i], exp_vec, exp_lat);
         run_op(ops[i], as[i], bs[i], holds[i], got, lat);
         checks++;
         if (got !== exp_vec) begin
            errors++;
            $display("FAIL %s[%0d] result/flags: got %h want %h", name, i, got, exp_vec);
         end
         checks++;
         if (lat != exp_lat) begin
            errors++;
            $display("FAIL %s[%0d] latency: got %0d want %0d", name, i, lat, exp_lat);
         end
      end
   endtask

   task automatic test_diff;
      test_directed("diff", '{3'd7, 3'd7, 3'd7}, '{32'd126, 32'd4, 32'hDEADBEEF},
                    '{32'd2, 32'd12, 32'hDEADBEEF}, '{0, 0, 1});
      // Spot-check against the literal expected values as well.
      checks++;
      if ({bus.result, bus.zero, bus.diff_eq} !== {32'd0, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL diff_equal_literal: got res %h z%b d%b want 0 z1 d1",
                  bus.result, bus.zero, bus.diff_eq);
      end
   endtask

   task automatic test_add_comp;
      test_directed("add_comp", '{3'd0, 3'd1}, '{32'hFFFFFFFF, 32'h12345678},
                    '{32'd1, 32'd5}, '{0, 0});
      checks++;
      if ({bus.result, bus.sign, bus.carry} !== {32'hFFFFFFFB, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL comp_literal: got res %h s%b c%b want fffffffb s1 c0",
                  bus.result, bus.sign, bus.carry);
      end
   endtask

   task automatic test_shifts;
      test_directed("shift", '{3'd6, 3'd4, 3'd5, 3'd4, 3'd6},
                    '{32'h80000001, 32'd1, 32'd3, 32'h80000001, 32'h40000000},
                    '{32'd4, 32'd0, 32'd1, 32'd31, 32'd31}, '{3, 0, 0, 0, 0});
   endtask

   task automatic test_reset_mid_shift;
      logic [35:0] got, exp_vec;
      int lat, exp_lat;
      @(negedge clk);
      bus.in_valid = 1'b1; bus.op = 3'd4; bus.a = 32'd1; bus.b = 32'd20;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      repeat (5) @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL mid_shift_busy: got vld %b rdy %b want 0 0", bus.out_valid, bus.in_ready);
      end
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus.out_valid, bus.in_ready, bus.result, bus.carry, bus.zero, bus.sign, bus.diff_eq}
          !== {1'b0, 1'b1, 36'h0}) begin
         errors++;
         $display("FAIL reset_mid_shift: got vld %b rdy %b res %h c%b z%b s%b d%b want vld 0 rdy 1 all 0",
                  bus.out_valid, bus.in_ready, bus.result, bus.carry, bus.zero, bus.sign, bus.diff_eq);
      end
      rst_n = 1'b1;
      model(3'd3, 32'hF0, 32'hFF, exp_vec, exp_lat);
      run_op(3'd3, 32'hF0, 32'hFF, 0, got, lat);
      checks++;
      if (got !== exp_vec || got[35:4] !== 32'h0F) begin
         errors++;
         $display("FAIL xor_after_reset: got %h want %h", got, exp_vec);
      end
   endtask

   task automatic test_random;
      logic [35:0] got, exp_vec;
      logic [31:0] a, b;
      logic [2:0]  op;
      int lat, exp_lat;
      for (int i = 0; i < 80; i++) begin
         op = 3'($urandom_range(0, 7));
         a  = $urandom;
         b  = $urandom;
         if (op == 3'd7 && $urandom_range(0, 3) == 0) b = a;
         if (op == 3'd7 && $urandom_range(0, 3) == 0) b = a ^ (32'd1 << $urandom_range(0, 31));
         model(op, a, b, exp_vec, exp_lat);
         run_op(op, a, b, $urandom_range(0, 2), got, lat);
         checks++;
         if (got !== exp_vec || lat != exp_lat) begin
            errors++;
            $display("FAIL random[%0d] op%0d a=%h b=%h: got %h lat %0d want %h lat %0d",
                     i, op, a, b, got, lat, exp_vec, exp_lat);
         end
      end
   endtask

   initial begin
      bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
      rst_n = 1'b0;
      test_reset();
      test_diff();
      test_add_comp();
      test_shifts();
      test_reset_mid_shift();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
